ps2_keyboard_receiver: RTL and testbench
========================================

PS2_KEYBOARD_RECEIVER -- requirements
Module: ps2_keyboard_receiver

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8, meaning consecutive equal ps2_clk samples required to accept a level change.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning clk cycles without a PS/2 falling edge before a partial frame is abandoned.
REQ-003 SHALL have port clk  input  1  system clock; the block has exactly one clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous to clk and active-high.
REQ-005 SHALL have port ps2_clk  input  1  keyboard clock, asynchronous.
REQ-006 SHALL have port ps2_data  input  1  keyboard data, asynchronous.
REQ-007 SHALL have port key_ack  input  1  consumer pulse; the pending event has been taken.
REQ-008 SHALL have port keycode  output  8  scan code of the last completed event.
REQ-009 SHALL have port key_status  output  8  bit0 is_break, bit1 extended (E0), bit2 valid, bit3 overrun, bits 7:4 always 0.

Function
REQ-010 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers before any use.
REQ-011 SHALL change the filtered ps2_clk only after FILTER_LEN consecutive identical synchronized samples; shorter glitches are ignored.
REQ-012 SHALL sample synchronized ps2_data on each filtered ps2_clk 1->0 transition, one sample per edge.
REQ-013 SHALL run frame FSM IDLE -> DATA -> PARITY -> STOP -> IDLE, 11 bits per frame.
REQ-014 SHALL stay in IDLE when the sampled start bit is 1; start bit 0 enters DATA.
REQ-015 SHALL shift 8 data bits LSB first in DATA, then sample the parity bit in PARITY, then the stop bit in STOP.
REQ-016 SHALL discard the frame when the stop bit is 0, leaving outputs unchanged.
REQ-017 SHALL, outside IDLE, return to IDLE and discard the partial frame when TIMEOUT_CYCLES cycles pass with no falling edge.
REQ-018 SHALL set an internal ext flag on accepted byte 0xE0 and an internal brk flag on accepted byte 0xF0; both give no output event.
REQ-019 SHALL, on any other accepted byte, update outputs on the cycle after the stop-bit edge: keycode=byte, bit0=brk, bit1=ext, bit2=1, then clear ext and brk.
REQ-020 SHALL set bit3 when an event completes while bit2 is already 1; the new event overwrites keycode and bits 2:0.
REQ-021 SHALL, on key_ack=1 with no event completing that cycle, clear key_status to 0x00 next cycle and hold keycode.
REQ-022 SHALL give a completing event priority over key_ack in the same cycle: the event is posted and bit3 is set, as if no ack occurred.
REQ-023 SHALL treat 0xE1, 0xAA and 0xFA as ordinary bytes.
REQ-024 SHALL leave ext/brk prefix flags intact across a discarded frame or a timeout.

Reset
REQ-025 SHALL, with rst=1 at a clk edge, force FSM to IDLE, clear shift register, bit counter, timeout counter, ext and brk, and set keycode=0x00 and key_status=0x00.
REQ-026 SHALL initialise filter state to 1 (bus idle) on reset; a reset mid-frame discards that frame.

Configuration
REQ-027 SHALL implement odd parity checking under macro PS2_PARITY_CHECK_EN.
REQ-028 SHALL, with PS2_PARITY_CHECK_EN defined, discard any frame whose 8 data bits plus parity bit have an even count of 1s, leaving outputs and prefix flags unchanged.
REQ-029 SHALL, without PS2_PARITY_CHECK_EN, sample the parity bit and ignore it.

Verification
REQ-030 SHALL pass this test: frame 0x1C with correct parity -> keycode=0x1C, key_status=0x04 one cycle after the stop edge; key_ack -> key_status=0x00 and keycode stays 0x1C.
REQ-031 SHALL pass this test: frames F0,1C -> keycode=0x1C, key_status=0x05; no event after the F0 frame alone.
REQ-032 SHALL pass this test: frames E0,F0,75 -> keycode=0x75, key_status=0x07; a following frame 75 -> key_status=0x04, showing flags cleared.
REQ-033 SHALL pass this test: frame 0x1C then 0x32 with no ack -> keycode=0x32, key_status=0x0C; key_ack pulsed on the 0x32 post cycle -> key_status remains 0x0C.
REQ-034 SHALL pass this test: 5 bits then silence for TIMEOUT_CYCLES+1, then full frame 0x29 -> keycode=0x29, key_status=0x04; 3-cycle ps2_clk glitches inside the frame have no effect.
REQ-035 SHALL pass this test: frame 0x1C with bad parity -> no update with PS2_PARITY_CHECK_EN defined; key_status=0x04 without it.

Source files
------------

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard receiver: synchronized, glitch-filtered clock; 11-bit frame FSM; E0/F0 prefix decode.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_keyboard_receiver #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       key_ack,
  output logic [7:0] keycode,
  output logic [7:0] key_status
);

  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t         state_q;
  state_t         state_d;

  logic           clk_meta;
  logic           clk_s;
  logic           data_meta;
  logic           data_s;

  logic           filt_clk;
  logic [FW-1:0]  filt_cnt;
  logic           filt_done;
  logic           fall;

  logic [7:0]     shift_q;
  logic [2:0]     bit_cnt;
  logic [TW-1:0]  to_cnt;
  logic           parity_ok;
  logic           frame_ok;

  logic           ext_q;
  logic           brk_q;
  logic           post_q;
  logic [7:0]     post_code;
  logic           post_ext;
  logic           post_brk;

  // Two-flop synchronizers; reset to the idle-high bus level.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta  <= 1'b1;
      clk_s     <= 1'b1;
      data_meta <= 1'b1;
      data_s    <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_s     <= clk_meta;
      data_meta <= ps2_data;
      data_s    <= data_meta;
    end
  end

  // The filtered clock flips on the FILTER_LEN-th consecutive differing sample.
  assign filt_done = (clk_s != filt_clk) && (filt_cnt == FW'(FILTER_LEN - 1));
  assign fall      = filt_done && filt_clk;

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_done) begin
      filt_clk <= clk_s;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    frame_ok = 1'b0;
    case (state_q)
      S_IDLE:   if (fall && !data_s) state_d = S_DATA;
      S_DATA:   if (fall && bit_cnt == 3'd7) state_d = S_PARITY;
      S_PARITY: if (fall) state_d = S_STOP;
      S_STOP: begin
        if (fall) begin
          state_d  = S_IDLE;
          frame_ok = data_s && parity_ok;
        end
      end
      default:  state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && !fall && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bit_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE || fall) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TW'(1);
      end
      if (state_q == S_IDLE) begin
        bit_cnt <= '0;
      end else if (fall && state_q == S_DATA) begin
        shift_q <= {data_s, shift_q[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (fall && state_q == S_PARITY) begin
      parity_q <= data_s;
    end
  end

  assign parity_ok = ^{shift_q, parity_q};
`else
  assign parity_ok = 1'b1;
`endif

  // Prefix bytes only arm flags; other bytes are staged one cycle before posting.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      post_q    <= 1'b0;
      post_code <= '0;
      post_ext  <= 1'b0;
      post_brk  <= 1'b0;
    end else begin
      post_q <= 1'b0;
      if (frame_ok) begin
        if (shift_q == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (shift_q == 8'hF0) begin
          brk_q <= 1'b1;
        end else begin
          post_q    <= 1'b1;
          post_code <= shift_q;
          post_ext  <= ext_q;
          post_brk  <= brk_q;
          ext_q     <= 1'b0;
          brk_q     <= 1'b0;
        end
      end
    end
  end

  // A posting event wins over a same-cycle ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      keycode    <= '0;
      key_status <= '0;
    end else if (post_q) begin
      keycode    <= post_code;
      key_status <= {4'b0000, key_status[2], 1'b1, post_ext, post_brk};
    end else if (key_ack) begin
      key_status <= '0;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Self-checking bench for ps2_keyboard_receiver: directed PS/2 frames against a byte-level model.
module tb_ps2_keyboard_receiver;

  localparam int unsigned FL   = 8;
  localparam int unsigned TO   = 1000;
  localparam int unsigned HALF = 20;

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       key_ack;
  logic [7:0] keycode;
  logic [7:0] key_status;

  int   checks = 0;
  int   errors = 0;
  logic chk_en = 1'b0;

  logic [7:0] exp_code;
  logic [7:0] exp_status;
  logic       m_ext;
  logic       m_brk;

  ps2_keyboard_receiver #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key_ack   (key_ack),
    .keycode   (keycode),
    .key_status(key_status)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (keycode !== exp_code || key_status !== exp_status) begin
        errors++;
        if (errors < 20)
          $display("FAIL cycle_check t=%0t keycode=%h key_status=%h required keycode=%h key_status=%h",
                   $time, keycode, key_status, exp_code, exp_status);
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input logic [7:0] k, input logic [7:0] s);
    checks++;
    if (keycode !== k || key_status !== s) begin
      errors++;
      $display("FAIL %s keycode=%h key_status=%h required keycode=%h key_status=%h",
               name, keycode, key_status, k, s);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      exp_status = {4'h0, exp_status[2], 1'b1, m_ext, m_brk};
      exp_code   = b;
      m_ext      = 1'b0;
      m_brk      = 1'b0;
    end
  endtask

  task automatic model_reset();
    exp_code   = 8'h00;
    exp_status = 8'h00;
    m_ext      = 1'b0;
    m_brk      = 1'b0;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int unsigned nbits,
                           input bit glitch, input bit ack_post);
    for (int unsigned i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (glitch) begin
        tick(12); ps2_clk = 1'b0; tick(3); ps2_clk = 1'b1; tick(HALF - 15);
      end else begin
        tick(HALF);
      end
      if (i == 10) chk_en = 1'b0;
      ps2_clk = 1'b0;
      if (i == 10 && ack_post) begin
        tick(FL + 2); key_ack = 1'b1; tick(1); key_ack = 1'b0; tick(HALF - FL - 3);
      end else if (glitch) begin
        tick(12); ps2_clk = 1'b1; tick(3); ps2_clk = 1'b0; tick(HALF - 15);
      end else begin
        tick(HALF);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit par_good, input bit stop);
    logic p;
    p = ~^b;
    if (!par_good) p = ~p;
    return {stop, p, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit par_good = 1'b1, input bit stop = 1'b1,
                            input bit glitch = 1'b0, input bit ack_post = 1'b0);
    send_bits(make_frame(b, par_good, stop), 11, glitch, ack_post);
    tick(HALF);
    if (stop && (par_good || !PAR_EN)) model_byte(b);
    chk_en = 1'b1;
  endtask

  task automatic do_ack();
    chk_en  = 1'b0;
    key_ack = 1'b1;
    tick(1);
    key_ack    = 1'b0;
    exp_status = 8'h00;
    chk_en     = 1'b1;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst    = 1'b1;
    tick(2);
    rst = 1'b0;
    model_reset();
    chk_en = 1'b1;
  endtask

  initial begin
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    key_ack  = 1'b0;
    model_reset();
    tick(3);
    rst = 1'b0;
    check_lit("reset", 8'h00, 8'h00);
    chk_en = 1'b1;
    tick(5);

    send_frame(8'h1C);
    check_lit("make_1c", 8'h1C, 8'h04);
    do_ack();
    check_lit("ack_1c", 8'h1C, 8'h00);

    send_frame(8'hF0);
    check_lit("f0_alone", 8'h1C, 8'h00);
    send_frame(8'h1C);
    check_lit("break_1c", 8'h1C, 8'h05);
    do_ack();

    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75);
    check_lit("ext_break_75", 8'h75, 8'h07);
    do_ack();
    send_frame(8'h75);
    check_lit("flags_cleared_75", 8'h75, 8'h04);
    do_ack();

    send_frame(8'h1C);
    send_frame(8'h32, 1'b1, 1'b1, 1'b0, 1'b1);
    check_lit("overrun_ack_post", 8'h32, 8'h0C);
    do_ack();
    check_lit("overrun_acked", 8'h32, 8'h00);

    send_bits(make_frame(8'h29, 1'b1, 1'b1), 5, 1'b0, 1'b0);
    tick(TO + 1);
    send_frame(8'h29, 1'b1, 1'b1, 1'b1, 1'b0);
    check_lit("timeout_glitch_29", 8'h29, 8'h04);
    do_ack();

    send_frame(8'hF0);
    send_frame(8'h1C, 1'b1, 1'b0);
    check_lit("bad_stop", 8'h29, 8'h00);
    send_frame(8'h1C);
    check_lit("brk_kept_after_bad_stop", 8'h1C, 8'h05);
    do_ack();

    send_frame(8'h1C, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    check_lit("bad_parity", 8'h1C, 8'h00);
`else
    check_lit("bad_parity", 8'h1C, 8'h04);
`endif
    do_ack();
    send_frame(8'hF0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h33);
    do_ack();

    send_frame(8'hE1);
    check_lit("plain_e1", 8'hE1, 8'h04);
    send_frame(8'hAA);
    check_lit("plain_aa", 8'hAA, 8'h0C);
    do_ack();
    send_frame(8'hFA);
    check_lit("plain_fa", 8'hFA, 8'h04);
    do_ack();

    send_frame(8'hE0);
    send_bits(make_frame(8'h5A, 1'b1, 1'b1), 5, 1'b0, 1'b0);
    tick(HALF);
    do_reset();
    check_lit("reset_mid_frame", 8'h00, 8'h00);
    send_frame(8'h1C);
    check_lit("after_reset_1c", 8'h1C, 8'h04);

    tick(10);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
